// File: rtl/lut_addr_gen.sv
// Front end for the interpolation coefficient LUTs: classifies r^2, forms the
// {segment, bin} LUT address and re-times r^2/tag to line up with the LUT q.
module lut_addr_gen #(
    parameter int unsigned TAG_WIDTH   = 16,
    parameter int unsigned MIN_EXP     = 113,
    parameter int unsigned SEGMENTS    = 14,
    parameter int unsigned BINS_LOG2   = 8,
    parameter logic [31:0] CUTOFF_2    = 32'h3F800000,
    parameter int unsigned LUT_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [31:0]            in_r2,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   cnt_clr,
    output logic [3+BINS_LOG2:0]   lut_addr,
    output logic                   lut_rden,
    output logic                   out_valid,
    output logic [31:0]            out_r2,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   err_underflow,
    output logic                   err_invalid,
    output logic [31:0]            pair_cnt,
    output logic [31:0]            drop_cnt
);

    localparam int unsigned SEG_W  = 4;
    localparam int unsigned ADDR_W = SEG_W + BINS_LOG2;
    // Stage 0 is the lut_rden cycle; the last stage is coincident with LUT q.
    localparam int unsigned DEPTH  = LUT_LATENCY + 1;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic                 sign_c;
    logic [7:0]           exp_c;
    logic [7:0]           seg_full_c;
    logic [BINS_LOG2-1:0] bin_c;
    logic                 is_invalid_c;
    logic                 is_under_c;
    logic                 is_cut_c;
    logic                 is_over_c;
    logic                 accept_c;
    logic                 cut_drop_c;
    logic                 invalid_hit_c;
    logic                 under_hit_c;

    logic [ADDR_W-1:0]    lut_addr_d,    lut_addr_q;
    logic                 err_under_d,   err_under_q;
    logic                 err_inv_d,     err_inv_q;
    logic [31:0]          pair_cnt_d,    pair_cnt_q;
    logic [31:0]          drop_cnt_d,    drop_cnt_q;
    logic                 dl_valid_d [DEPTH];
    logic                 dl_valid_q [DEPTH];
    logic [31:0]          dl_r2_d    [DEPTH];
    logic [31:0]          dl_r2_q    [DEPTH];
    logic [TAG_WIDTH-1:0] dl_tag_d   [DEPTH];
    logic [TAG_WIDTH-1:0] dl_tag_q   [DEPTH];

    // Decode and priority classification of the incoming operand.
    always_comb begin
        sign_c        = in_r2[31];
        exp_c         = in_r2[30:23];
        seg_full_c    = exp_c - 8'(MIN_EXP);
        bin_c         = in_r2[22 -: BINS_LOG2];
        is_invalid_c  = sign_c | (exp_c == 8'hFF);
        is_under_c    = exp_c < 8'(MIN_EXP);
        is_cut_c      = in_r2[30:0] >= CUTOFF_2[30:0];
        is_over_c     = seg_full_c >= 8'(SEGMENTS);
        invalid_hit_c = in_valid & is_invalid_c;
        under_hit_c   = in_valid & ~is_invalid_c & is_under_c;
        cut_drop_c    = in_valid & ~is_invalid_c & ~is_under_c & (is_cut_c | is_over_c);
        accept_c      = in_valid & ~is_invalid_c & ~is_under_c & ~is_cut_c & ~is_over_c;
    end

    // Next-state for address, delay line, sticky flags and counters.
    always_comb begin
        lut_addr_d  = lut_addr_q;
        err_under_d = err_under_q | under_hit_c;
        err_inv_d   = err_inv_q | invalid_hit_c;
        pair_cnt_d  = pair_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (accept_c) begin
            lut_addr_d = ADDR_W'({seg_full_c[SEG_W-1:0], bin_c});
        end

        dl_valid_d[0] = accept_c;
        dl_r2_d[0]    = accept_c ? in_r2  : dl_r2_q[0];
        dl_tag_d[0]   = accept_c ? in_tag : dl_tag_q[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_r2_d[i]    = dl_r2_q[i-1];
            dl_tag_d[i]   = dl_tag_q[i-1];
        end

        if (cnt_clr) begin
            pair_cnt_d = '0;
        end else if (accept_c && (pair_cnt_q != CNT_MAX)) begin
            pair_cnt_d = pair_cnt_q + 32'd1;
        end

        if (cnt_clr) begin
            drop_cnt_d = '0;
        end else if (cut_drop_c && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_addr_q  <= '0;
            err_under_q <= 1'b0;
            err_inv_q   <= 1'b0;
            pair_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_r2_q[i]    <= '0;
                dl_tag_q[i]   <= '0;
            end
        end else begin
            lut_addr_q  <= lut_addr_d;
            err_under_q <= err_under_d;
            err_inv_q   <= err_inv_d;
            pair_cnt_q  <= pair_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dl_valid_q[i] <= dl_valid_d[i];
                dl_r2_q[i]    <= dl_r2_d[i];
                dl_tag_q[i]   <= dl_tag_d[i];
            end
        end
    end

    assign lut_addr      = lut_addr_q;
    assign lut_rden      = dl_valid_q[0];
    assign out_valid     = dl_valid_q[DEPTH-1];
    assign out_r2        = dl_r2_q[DEPTH-1];
    assign out_tag       = dl_tag_q[DEPTH-1];
    assign err_underflow = err_under_q;
    assign err_invalid   = err_inv_q;
    assign pair_cnt      = pair_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: doc/lut_addr_gen.md
# lut_addr_gen

Pipelined front end for the interpolation coefficient memories in the range-limited force pipeline. Takes a single-precision r² per particle pair, filters out pairs at or beyond the cutoff and invalid operands, and derives the 12-bit segment/bin address into the 14-segment × 256-bin coefficient LUTs. It drives the shared LUT read port and re-times r² and the pair tag so that they leave the block in the same cycle the LUT coefficients appear. Sits between the pair filter and the LUTs / polynomial evaluator.

## Interface
Parameters:
- TAG_WIDTH, 16: width of the pair tag carried alongside r².
- MIN_EXP, 113: biased IEEE-754 exponent of segment 0; segment 0 covers [2^-14, 2^-13).
- SEGMENTS, 14: number of segments; 4-bit segment field.
- BINS_LOG2, 8: bins per segment = 256, taken from mantissa[22:15].
- CUTOFF_2, 32'h3F800000: r² cutoff as a float bit pattern; must be ≤ 2^(MIN_EXP−127+SEGMENTS).
- LUT_LATENCY, 1: read latency of the LUT, in cycles from address to q; legal range 1–2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  r² and tag valid this cycle.
- in_r2  in  32  r², single precision.
- in_tag  in  TAG_WIDTH  pair identifier.
- cnt_clr  in  1  synchronous clear of the statistics counters.
- lut_addr  out  12  LUT address = {seg[3:0], bin[7:0]}.
- lut_rden  out  1  LUT read enable. The LUT wren is tied 0 by the parent.
- out_valid  out  1  asserted in the same cycle the LUT q is valid for this pair.
- out_r2  out  32  r² aligned with LUT q.
- out_tag  out  TAG_WIDTH  tag aligned with LUT q.
- err_underflow  out  1  sticky; set when an r² below 2^(MIN_EXP−127) is seen.
- err_invalid  out  1  sticky; set when an input is negative, NaN or Inf.
- pair_cnt  out  32  number of accepted pairs; saturating.
- drop_cnt  out  32  number of cutoff drops; saturating.

## Operation
- No backpressure: one pair is accepted per cycle, every cycle. The downstream evaluator is fully pipelined.
- Decode on in_valid:
  - sign = in_r2[31].
  - e = in_r2[30:23].
  - seg = e − MIN_EXP.
  - bin = in_r2[22:15].
- Classification, evaluated in priority order:
  - sign = 1, or e = 255: invalid. Drop the pair and set err_invalid.
  - e < MIN_EXP (this includes zero and denormals): underflow. Drop the pair and set err_underflow.
  - in_r2 ≥ CUTOFF_2, compared as unsigned 31-bit magnitude: cutoff. Drop the pair and increment drop_cnt.
  - seg ≥ SEGMENTS: overflow. Treated as a cutoff drop; this case is unreachable when CUTOFF_2 is legal.
  - Otherwise: accept. Issue lut_rden with lut_addr = seg*256 + bin, and increment pair_cnt.
- A dropped pair produces no lut_rden and no out_valid. lut_addr holds its previous value.
- Delay line: LUT_LATENCY register stages carry {valid, r², tag} from the lut_rden cycle to the output.
- Counters:
  - Saturate at 32'hFFFFFFFF.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- The err_* flags clear only on rst.

## Timing
- Input sampled at edge E0.
- lut_addr and lut_rden are registered outputs, valid in the cycle after E0.
- out_valid, out_r2 and out_tag are valid LUT_LATENCY cycles after lut_rden, coincident with q.
- Total latency from input to output: 1 + LUT_LATENCY cycles. Throughput: 1 pair per cycle.
- Reset (asynchronous assert, synchronous-safe deassert):
  - lut_addr = 0, lut_rden = 0.
  - out_valid = 0, out_r2 = 0, out_tag = 0.
  - err_underflow = 0, err_invalid = 0.
  - pair_cnt = 0, drop_cnt = 0.
  - All delay-line valid bits = 0.
- Reset mid-stream: in-flight pairs are discarded; no out_valid appears after reset deasserts until a new input is accepted.
- Back-to-back inputs: distinct addresses on consecutive cycles. Outputs appear in input order with no bubbles, except at drops.

## Test plan
- After reset, apply in_r2 = 32'h3F000000 (0.5) with tag 5 → lut_addr = 12'hD00 and lut_rden = 1 at cycle 1; out_valid with out_r2 = 32'h3F000000 and out_tag = 5 at cycle 1 + LUT_LATENCY; pair_cnt = 1.
- Segment edges:
  - 32'h38800000 → addr 12'h000.
  - 32'h3F7FFFFF → addr 12'hDFF.
  - 32'h3E400000 → addr 12'hB80.
  - Applied on 3 consecutive cycles → 3 back-to-back out_valid pulses in order.
- 32'h3F800000 (at cutoff) and 32'h40000000 → no lut_rden, no out_valid; drop_cnt = 2; pair_cnt unchanged.
- 32'h38400000 → dropped, err_underflow = 1. 32'hBF000000 → dropped, err_invalid = 1. 32'h7FC00000 → dropped. Both flags remain set until rst.
- Preload pair_cnt to 32'hFFFFFFFE via a forced test, then 3 accepts → counter saturates at 32'hFFFFFFFF. cnt_clr asserted together with an accept → 0.
- Assert rst while 2 pairs are in flight → all outputs 0 immediately; no out_valid after release. Repeat the full suite with LUT_LATENCY = 2 and verify alignment with a LUT model of matching latency.
